c16_prg_loader: RTL
===================

# c16_prg_loader

Sequences host-side PRG file injection into C16 main RAM. It parses the 2-byte PRG load-address header and streams the data bytes into RAM. Writes happen only in RAM slots the C16 bus leaves free. After the file ends, it patches the BASIC end-of-program pointers. It sits between the host download port and the RAM mux, and stalls the C16 CPU (WAIT) for the whole operation.

## Interface
- ADDR_W, 16, RAM address width (C16 address bus).
- PTR_BASE, 16'h002D, first of three little-endian BASIC pointers patched at end (VARTAB/ARYTAB/STREND).
- CLK28  in  1  system clock (28 MHz).
- RESET_N  in  1  reset, asynchronous, active-low.
- dl_start  in  1  1-cycle pulse: begin new PRG download.
- dl_wr  in  1  1-cycle pulse: dl_data valid. Legal only when dl_busy=0.
- dl_data  in  8  download byte.
- dl_end  in  1  1-cycle pulse: file complete.
- dl_busy  out  1  back-pressure to host.
- slot  in  1  1-cycle pulse: RAM free for one write this cycle.
- ram_addr  out  ADDR_W  write address (registered).
- ram_dout  out  8  write data (registered).
- ram_we  out  1  write strobe = slot & pending (combinational, same cycle as slot).
- cpu_hold  out  1  drives C16 WAIT.
- loading  out  1  high while not IDLE.
- error  out  1  sticky until next dl_start: header short or address overflow.

## Operation
- States: IDLE, HDR_LO, HDR_HI, DATA, FLUSH, PATCH.
- IDLE:
  - dl_start -> HDR_LO; clear error; set cpu_hold.
  - dl_wr/dl_end ignored.
- HDR_LO: dl_wr latches load_addr[7:0] -> HDR_HI.
- HDR_HI: dl_wr latches load_addr[15:8]; wptr<=load_addr -> DATA.
- DATA:
  - dl_wr loads the 1-deep buffer (ram_addr<=wptr, ram_dout<=dl_data, pending<=1).
  - On the slot write: wptr<=wptr+1, pending<=0.
- Overflow: a byte accepted when wptr wrapped past 16'hFFFF (17-bit carry set) is dropped. error<=1, and all further bytes are discarded, but still handshaken.
- dl_end in DATA -> FLUSH.
  - FLUSH waits for pending=0.
  - Then go to PATCH if error=0, else IDLE.
- dl_end in HDR_LO/HDR_HI: error<=1 -> IDLE, no RAM writes.
- PATCH issues 6 writes, one per slot: PTR_BASE+0..5 <= wptr[7:0], wptr[15:8], repeated ×3. Then -> IDLE.
- dl_start in any non-IDLE state:
  - Abort: pending dropped, no partial patch.
  - Go to HDR_LO; error cleared.
- cpu_hold = (state != IDLE).
- Reset (any time, including mid-write): all state cleared, pending dropped. All outputs go 0: ram_addr=0, ram_dout=0, error=0, dl_busy=0, cpu_hold=0.

## Timing
- dl_busy = pending | (state==FLUSH) | (state==PATCH). It rises the cycle after a DATA-state dl_wr.
- Header bytes never raise dl_busy. Consecutive header dl_wr on back-to-back cycles are accepted.
- Write latency: a byte accepted in cycle n is written at the first slot with cycle ≥ n+1.
  - A slot in cycle n itself does not write that byte.
- Throughput: 1 byte per slot, max one every 2 cycles.
- dl_end coincident with dl_wr: the byte is accepted first, then FLUSH.
- dl_start coincident with slot while pending: the write still occurs (ram_we combinational), then the abort takes effect.
- cpu_hold falls the cycle after the 6th PATCH write, or the cycle after the abort-to-IDLE / error-to-IDLE transition.

## Test plan
- PRG header 01 10, data AA BB CC; slot every 4 cycles; dl_end:
  - RAM writes $1001=AA, $1002=BB, $1003=CC.
  - Then $2D..$32 = 04 10 04 10 04 10.
  - cpu_hold is low afterwards; error=0.
- dl_wr held off by host honouring dl_busy, with slot starved for 50 cycles: dl_busy stays high and no data lost. The first slot writes the byte and dl_busy drops next cycle.
- Header FF FF, data 11 22: $FFFF=11 written; 22 dropped; error=1; no PATCH writes; cpu_hold falls after dl_end.
- dl_start, one byte 01, dl_end: error=1, zero ram_we pulses, return to IDLE.
- dl_start mid-DATA with a byte pending and no slot: that byte is never written. The new header is parsed, and the new file loads and patches correctly.
- RESET_N low during PATCH (after 3 writes): all outputs 0 immediately. After release, stays IDLE; ram_we=0 even with slot pulses.

Source files
------------

// File: rtl/c16_prg_loader_if.sv
// Host download port plus RAM-mux write port of the C16 PRG loader.
// slave = loader side, master = host/RAM-mux side.
interface c16_prg_loader_if #(
  parameter int ADDR_W = 16
);
  logic              dl_start;
  logic              dl_wr;
  logic [7:0]        dl_data;
  logic              dl_end;
  logic              dl_busy;
  logic              slot;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_dout;
  logic              ram_we;
  logic              cpu_hold;
  logic              loading;
  logic              error;

  modport slave (
    input  dl_start, dl_wr, dl_data, dl_end, slot,
    output dl_busy, ram_addr, ram_dout, ram_we, cpu_hold, loading, error
  );

  modport master (
    output dl_start, dl_wr, dl_data, dl_end, slot,
    input  dl_busy, ram_addr, ram_dout, ram_we, cpu_hold, loading, error
  );
endinterface

// File: rtl/c16_prg_loader.sv
// Streams a host PRG file (2-byte load address + data) into C16 RAM using free
// bus slots, then patches the BASIC VARTAB/ARYTAB/STREND pointers.
module c16_prg_loader #(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] PTR_BASE = ADDR_W'(16'h002D)
) (
  input logic             CLK28,
  input logic             RESET_N,
  c16_prg_loader_if.slave bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_HDR_LO = 3'd1;
  localparam logic [2:0] S_HDR_HI = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_FLUSH  = 3'd4;
  localparam logic [2:0] S_PATCH  = 3'd5;

  logic [2:0]        state_reg,   state_next;
  // One extra bit so a write past the top of memory is detectable.
  logic [ADDR_W:0]   wptr_reg,    wptr_next;
  logic [7:0]        hdr_lo_reg,  hdr_lo_next;
  logic              pending_reg, pending_next;
  logic              error_reg,   error_next;
  logic [2:0]        idx_reg,     idx_next;
  logic [ADDR_W-1:0] addr_reg,    addr_next;
  logic [7:0]        dout_reg,    dout_next;
  logic              wr_done;

  assign wr_done      = bus.slot & pending_reg;
  assign bus.ram_we   = wr_done;
  assign bus.ram_addr = addr_reg;
  assign bus.ram_dout = dout_reg;
  assign bus.error    = error_reg;
  assign bus.loading  = (state_reg != S_IDLE);
  assign bus.cpu_hold = (state_reg != S_IDLE);
  assign bus.dl_busy  = pending_reg | (state_reg == S_FLUSH) | (state_reg == S_PATCH);

  always_comb begin
    state_next   = state_reg;
    wptr_next    = wptr_reg;
    hdr_lo_next  = hdr_lo_reg;
    pending_next = pending_reg;
    error_next   = error_reg;
    idx_next     = idx_reg;
    addr_next    = addr_reg;
    dout_next    = dout_reg;

    if (wr_done) begin
      pending_next = 1'b0;
      if (state_reg == S_DATA || state_reg == S_FLUSH)
        wptr_next = wptr_reg + (ADDR_W+1)'(1);
    end

    case (state_reg)
      S_HDR_LO: begin
        if (bus.dl_end) begin
          error_next = 1'b1;
          state_next = S_IDLE;
        end else if (bus.dl_wr) begin
          hdr_lo_next = bus.dl_data;
          state_next  = S_HDR_HI;
        end
      end
      S_HDR_HI: begin
        if (bus.dl_end) begin
          error_next = 1'b1;
          state_next = S_IDLE;
        end else if (bus.dl_wr) begin
          wptr_next  = {1'b0, ADDR_W'({bus.dl_data, hdr_lo_reg})};
          state_next = S_DATA;
        end
      end
      S_DATA: begin
        if (bus.dl_wr && !pending_reg) begin
          // Past the top of memory: drop the byte but keep handshaking.
          if (wptr_reg[ADDR_W] || error_reg) begin
            error_next = 1'b1;
          end else begin
            addr_next    = wptr_reg[ADDR_W-1:0];
            dout_next    = bus.dl_data;
            pending_next = 1'b1;
          end
        end
        if (bus.dl_end)
          state_next = S_FLUSH;
      end
      S_FLUSH: begin
        if (!pending_reg) begin
          if (error_reg) begin
            state_next = S_IDLE;
          end else begin
            state_next   = S_PATCH;
            addr_next    = PTR_BASE;
            dout_next    = wptr_reg[7:0];
            pending_next = 1'b1;
            idx_next     = 3'd0;
          end
        end
      end
      S_PATCH: begin
        // Six pointer bytes: lo/hi of the end address, three times.
        if (wr_done) begin
          if (idx_reg == 3'd5) begin
            state_next = S_IDLE;
          end else begin
            idx_next     = idx_reg + 3'd1;
            addr_next    = addr_reg + ADDR_W'(1);
            dout_next    = idx_reg[0] ? wptr_reg[7:0] : wptr_reg[15:8];
            pending_next = 1'b1;
          end
        end
      end
      default: ;
    endcase

    // A new download always wins, aborting whatever is in flight.
    if (bus.dl_start) begin
      state_next   = S_HDR_LO;
      error_next   = 1'b0;
      pending_next = 1'b0;
    end
  end

  always_ff @(posedge CLK28 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_reg   <= S_IDLE;
      wptr_reg    <= '0;
      hdr_lo_reg  <= '0;
      pending_reg <= 1'b0;
      error_reg   <= 1'b0;
      idx_reg     <= '0;
      addr_reg    <= '0;
      dout_reg    <= '0;
    end else begin
      state_reg   <= state_next;
      wptr_reg    <= wptr_next;
      hdr_lo_reg  <= hdr_lo_next;
      pending_reg <= pending_next;
      error_reg   <= error_next;
      idx_reg     <= idx_next;
      addr_reg    <= addr_next;
      dout_reg    <= dout_next;
    end
  end

endmodule
